// File: rtl/pll_clk_monitor_if.sv
// Signal bundle between the PLL clock monitor (slave) and the side that drives
// the lock/clocks/expectations and observes results (master). duty_ok exists only with PLL_MON_DUTY_EN.
interface pll_clk_monitor_if #(
    parameter int NUM_CLK = 3,
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 3
);
    logic                     pll_lock;
    logic [NUM_CLK-1:0]       mon_clk;
    logic [NUM_CLK*CNT_W-1:0] exp_cnt;
    logic [NUM_CLK*CNT_W-1:0] meas_cnt;
    logic [NUM_CLK-1:0]       freq_ok;
    logic                     win_done;
    logic                     lock_err;
    logic [1:0]               lock_rise_cnt;
    logic [ERR_W-1:0]         err_cnt;
    logic                     err_flag;
`ifdef PLL_MON_DUTY_EN
    logic [NUM_CLK-1:0]       duty_ok;

    modport master (
        output pll_lock, mon_clk, exp_cnt,
        input  meas_cnt, freq_ok, win_done, lock_err, lock_rise_cnt, err_cnt, err_flag, duty_ok
    );
    modport slave (
        input  pll_lock, mon_clk, exp_cnt,
        output meas_cnt, freq_ok, win_done, lock_err, lock_rise_cnt, err_cnt, err_flag, duty_ok
    );
`else
    modport master (
        output pll_lock, mon_clk, exp_cnt,
        input  meas_cnt, freq_ok, win_done, lock_err, lock_rise_cnt, err_cnt, err_flag
    );
    modport slave (
        input  pll_lock, mon_clk, exp_cnt,
        output meas_cnt, freq_ok, win_done, lock_err, lock_rise_cnt, err_cnt, err_flag
    );
`endif
endinterface

// File: rtl/pll_clk_monitor.sv
// PLL output clock monitor: per-window edge counting against expectations, lock-loss/relock tracking
// and a saturating error count. Define PLL_MON_DUTY_EN to add per-channel duty-cycle checking.
module pll_clk_monitor #(
    parameter int NUM_CLK    = 3,
    parameter int CNT_W      = 16,
    parameter int WIN_CYC    = 1000,
    parameter int SETTLE_CYC = 64,
    parameter int TOL        = 2,
    parameter int ERR_W      = 3
) (
    input logic              clk_tb,
    input logic              rst_n,
    pll_clk_monitor_if.slave bus
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W + 1)'(TOL);
`ifdef PLL_MON_DUTY_EN
    localparam int DUTY_MID = WIN_CYC / 2;
    localparam int DUTY_TOL = WIN_CYC / 16;
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, CHECK} state_t;

    state_t                   state;
    logic [1:0]               rst_sync;
    logic                     rst_int_n;
    logic [2:0]               lock_sh;
    logic                     lock_rise;
    logic                     lock_fall;
    logic [NUM_CLK-1:0]       mon_s0;
    logic [NUM_CLK-1:0]       mon_s1;
    logic [NUM_CLK-1:0]       mon_d;
    logic [NUM_CLK-1:0]       mon_edge;
    logic [SET_W-1:0]         settle_cnt;
    logic [CNT_W-1:0]         win_cnt;
    logic [CNT_W-1:0]         edge_cnt [NUM_CLK];
    logic [CNT_W-1:0]         exp_lat  [NUM_CLK];
    logic [CNT_W:0]           diff     [NUM_CLK];
    logic [NUM_CLK-1:0]       freq_pass;
    logic                     check_fail;
    logic [NUM_CLK*CNT_W-1:0] meas_q;
    logic [NUM_CLK-1:0]       freq_q;
    logic                     win_done_q;
    logic                     lock_err_q;
    logic [1:0]               rise_q;
    logic [ERR_W-1:0]         err_q;
    logic [ERR_W-1:0]         err_next;
    logic                     err_flag_q;
    logic                     ev_any;
`ifdef PLL_MON_DUTY_EN
    logic [CNT_W-1:0]         high_cnt [NUM_CLK];
    logic [NUM_CLK-1:0]       duty_pass;
    logic [NUM_CLK-1:0]       duty_q;
`endif

    // Asynchronous assertion, deassertion released through two flops.
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_ff @(posedge clk_tb or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_sh <= '0;
            mon_s0  <= '0;
            mon_s1  <= '0;
            mon_d   <= '0;
        end else begin
            lock_sh <= {lock_sh[1:0], bus.pll_lock};
            mon_s0  <= bus.mon_clk;
            mon_s1  <= mon_s0;
            mon_d   <= mon_s1;
        end
    end

    assign lock_rise = lock_sh[1] & ~lock_sh[2];
    assign lock_fall = ~lock_sh[1] & lock_sh[2];
    assign mon_edge  = mon_s1 & ~mon_d;

    always_comb begin
        freq_pass = '0;
        for (int unsigned i = 0; i < NUM_CLK; i++) begin
            diff[i] = (edge_cnt[i] >= exp_lat[i]) ? ({1'b0, edge_cnt[i]} - {1'b0, exp_lat[i]})
                                                   : ({1'b0, exp_lat[i]} - {1'b0, edge_cnt[i]});
            freq_pass[i] = (diff[i] <= TOL_V);
        end
    end

`ifdef PLL_MON_DUTY_EN
    always_comb begin
        duty_pass = '0;
        for (int unsigned i = 0; i < NUM_CLK; i++) begin
            duty_pass[i] = (int'(high_cnt[i]) >= DUTY_MID - DUTY_TOL) &&
                           (int'(high_cnt[i]) <= DUTY_MID + DUTY_TOL);
        end
    end
    assign check_fail = ~(&freq_pass) | ~(&duty_pass);
`else
    assign check_fail = ~(&freq_pass);
`endif

    // Coincident events collapse into a single increment.
    assign ev_any = (lock_fall && (state == MEASURE || state == CHECK)) ||
                    (state == CHECK && check_fail) ||
                    (lock_rise && rise_q != 2'd0);
    assign err_next = (ev_any && err_q != '1) ? err_q + ERR_W'(1) : err_q;

    always_ff @(posedge clk_tb or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            for (int unsigned i = 0; i < NUM_CLK; i++) begin
                edge_cnt[i] <= '0;
                exp_lat[i]  <= '0;
`ifdef PLL_MON_DUTY_EN
                high_cnt[i] <= '0;
`endif
            end
            meas_q     <= '0;
            freq_q     <= '0;
            win_done_q <= 1'b0;
            lock_err_q <= 1'b0;
            rise_q     <= '0;
            err_q      <= '0;
            err_flag_q <= 1'b0;
`ifdef PLL_MON_DUTY_EN
            duty_q     <= '0;
`endif
        end else begin
            win_done_q <= 1'b0;
            err_q      <= err_next;
            err_flag_q <= (err_next != '0);
            if (lock_rise) begin
                if (rise_q != 2'd3) rise_q <= rise_q + 2'd1;
                if (rise_q != 2'd0) lock_err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    win_cnt    <= '0;
                    for (int unsigned i = 0; i < NUM_CLK; i++) begin
                        edge_cnt[i] <= '0;
`ifdef PLL_MON_DUTY_EN
                        high_cnt[i] <= '0;
`endif
                    end
                    if (lock_rise) state <= SETTLE;
                end
                SETTLE: begin
                    if (lock_fall) begin
                        state <= IDLE;
                    end else if (settle_cnt == SET_LAST) begin
                        state   <= MEASURE;
                        win_cnt <= '0;
                        for (int unsigned i = 0; i < NUM_CLK; i++) begin
                            exp_lat[i]  <= bus.exp_cnt[i*CNT_W +: CNT_W];
                            edge_cnt[i] <= '0;
`ifdef PLL_MON_DUTY_EN
                            high_cnt[i] <= '0;
`endif
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                MEASURE: begin
                    // Lock loss wins over the terminal count: the window is discarded.
                    if (lock_fall) begin
                        state      <= IDLE;
                        lock_err_q <= 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_CLK; i++) begin
                            if (mon_edge[i] && edge_cnt[i] != '1)
                                edge_cnt[i] <= edge_cnt[i] + CNT_W'(1);
`ifdef PLL_MON_DUTY_EN
                            if (mon_s1[i]) high_cnt[i] <= high_cnt[i] + CNT_W'(1);
`endif
                        end
                        if (win_cnt == WIN_LAST) state <= CHECK;
                        else                     win_cnt <= win_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    for (int unsigned i = 0; i < NUM_CLK; i++)
                        meas_q[i*CNT_W +: CNT_W] <= edge_cnt[i];
                    freq_q     <= freq_pass;
`ifdef PLL_MON_DUTY_EN
                    duty_q     <= duty_pass;
`endif
                    win_done_q <= 1'b1;
                    win_cnt    <= '0;
                    // A lock loss landing on the check cycle still reports the finished window.
                    if (lock_fall) begin
                        state      <= IDLE;
                        lock_err_q <= 1'b1;
                    end else begin
                        state <= MEASURE;
                    end
                    for (int unsigned i = 0; i < NUM_CLK; i++) begin
                        exp_lat[i]  <= bus.exp_cnt[i*CNT_W +: CNT_W];
                        edge_cnt[i] <= '0;
`ifdef PLL_MON_DUTY_EN
                        high_cnt[i] <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.meas_cnt      = meas_q;
    assign bus.freq_ok       = freq_q;
    assign bus.win_done      = win_done_q;
    assign bus.lock_err      = lock_err_q;
    assign bus.lock_rise_cnt = rise_q;
    assign bus.err_cnt       = err_q;
    assign bus.err_flag      = err_flag_q;
`ifdef PLL_MON_DUTY_EN
    assign bus.duty_ok       = duty_q;
`endif
endmodule

// File: tb/tb_pll_clk_monitor.sv
// Randomized bench for pll_clk_monitor: expected counts, pass bits and error totals come from
// the ideal clock frequencies/duty and the monitor's rules applied per window.
`timescale 1ns/1ps
module tb_pll_clk_monitor;
    localparam int NUM_CLK    = 3;
    localparam int CNT_W      = 16;
    localparam int WIN_CYC    = 1000;
    localparam int SETTLE_CYC = 64;
    localparam int TOL        = 2;
    localparam int ERR_W      = 3;
    localparam realtime TCLK  = 2.0;

    logic clk_tb = 1'b0;
    logic rst_n;
    always #(TCLK / 2) clk_tb = ~clk_tb;

    pll_clk_monitor_if #(.NUM_CLK(NUM_CLK), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    pll_clk_monitor #(
        .NUM_CLK(NUM_CLK), .CNT_W(CNT_W), .WIN_CYC(WIN_CYC),
        .SETTLE_CYC(SETTLE_CYC), .TOL(TOL), .ERR_W(ERR_W)
    ) dut (
        .clk_tb(clk_tb),
        .rst_n (rst_n),
        .bus   (bus)
    );

    realtime          mon_per  [NUM_CLK] = '{20.0, 20.0, 20.0};
    real              mon_duty [NUM_CLK] = '{0.5, 0.5, 0.5};
    logic             mon_u    [NUM_CLK];
    logic [CNT_W-1:0] exp_v    [NUM_CLK];
    logic [CNT_W-1:0] win_exp  [NUM_CLK];
    realtime          per_opts [7] = '{10.0, 16.0, 20.0, 25.0, 40.0, 50.0, 80.0};

    for (genvar g = 0; g < NUM_CLK; g++) begin : g_mon
        initial begin
            mon_u[g] = 1'b0;
            #(0.37 * (g + 1));
            forever begin
                mon_u[g] = 1'b1;
                #(mon_per[g] * mon_duty[g]);
                mon_u[g] = 1'b0;
                #(mon_per[g] * (1.0 - mon_duty[g]));
            end
        end
    end
    assign bus.mon_clk = {mon_u[2], mon_u[1], mon_u[0]};
    assign bus.exp_cnt = {exp_v[2], exp_v[1], exp_v[0]};

    int n_checks = 0;
    int n_pass   = 0;
    int model_err;
    int model_rise;
    bit model_lock_err;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_tb);
    endtask

    // Returns negedges waited until win_done is seen, or -1 when the budget runs out.
    task automatic wait_win(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_tb);
            cyc++;
        end while (!bus.win_done && cyc < budget);
        check_val({tag, " win_done seen"}, bus.win_done, 1);
        if (!bus.win_done) cyc = -1;
    endtask

    function automatic int ideal_cnt(input int ch);
        return int'((WIN_CYC * TCLK) / mon_per[ch]);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Either clearly inside the tolerance or clearly outside it, never on the boundary.
    function automatic int pick_exp(input int ideal);
        int off;
        if ($urandom_range(0, 3) == 0) begin
            off = int'($urandom_range(0, 2)) - 1;
        end else begin
            off = int'($urandom_range(4, 20));
            if ($urandom_range(0, 1) == 1) off = -off;
        end
        return ideal + off;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_val({tag, " meas_cnt"}, bus.meas_cnt, 0);
        check_val({tag, " freq_ok"}, bus.freq_ok, 0);
        check_val({tag, " win_done"}, bus.win_done, 0);
        check_val({tag, " lock_err"}, bus.lock_err, 0);
        check_val({tag, " lock_rise_cnt"}, bus.lock_rise_cnt, 0);
        check_val({tag, " err_cnt"}, bus.err_cnt, 0);
        check_val({tag, " err_flag"}, bus.err_flag, 0);
`ifdef PLL_MON_DUTY_EN
        check_val({tag, " duty_ok"}, bus.duty_ok, 0);
`endif
    endtask

    task automatic check_status(input string tag);
        check_val({tag, " err_cnt"}, bus.err_cnt, model_err);
        check_val({tag, " err_flag"}, bus.err_flag, model_err != 0);
        check_val({tag, " lock_err"}, bus.lock_err, model_lock_err);
        check_val({tag, " lock_rise_cnt"}, bus.lock_rise_cnt, model_rise);
    endtask

    task automatic add_err();
        if (model_err < (1 << ERR_W) - 1) model_err++;
    endtask

    // Called on the cycle win_done is visible; win_exp holds what the finished window latched.
    task automatic check_window(input string tag);
        logic [NUM_CLK-1:0] f_exp;
        logic [NUM_CLK-1:0] d_exp;
        f_exp = '0;
        d_exp = '1;
        for (int i = 0; i < NUM_CLK; i++) begin
            int ideal;
            int meas;
            ideal = ideal_cnt(i);
            meas  = int'(bus.meas_cnt[i*CNT_W +: CNT_W]);
            check_val($sformatf("%s meas%0d=%0d ideal=%0d", tag, i, meas, ideal), iabs(meas - ideal) <= 1, 1);
            f_exp[i] = iabs(ideal - int'(win_exp[i])) <= TOL;
`ifdef PLL_MON_DUTY_EN
            d_exp[i] = iabs(int'(WIN_CYC * mon_duty[i]) - WIN_CYC / 2) <= WIN_CYC / 16;
`endif
        end
        check_val({tag, " freq_ok"}, bus.freq_ok, f_exp);
`ifdef PLL_MON_DUTY_EN
        check_val({tag, " duty_ok"}, bus.duty_ok, d_exp);
`endif
        if (!(&f_exp) || !(&d_exp)) add_err();
        check_status(tag);
        win_exp = exp_v;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cycles(10);
        rst_n = 1'b1;
        model_err      = 0;
        model_lock_err = 1'b0;
        model_rise     = 0;
    endtask

    initial begin
        int cyc;
        bit seen;
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) exp_v[i] = CNT_W'(100);
        win_exp        = exp_v;
        model_err      = 0;
        model_rise     = 0;
        model_lock_err = 1'b0;
        cycles(5);
        check_reset_vals("por");
        rst_n = 1'b1;
        cycles(5);

        // All channels 50 MHz, exp 100, single lock rise.
        bus.pll_lock = 1'b1;
        model_rise   = 1;
        wait_win("p1 first", 1300, cyc);
        check_val($sformatf("p1 first latency=%0d", cyc),
                  (cyc >= SETTLE_CYC + WIN_CYC + 3) && (cyc <= SETTLE_CYC + WIN_CYC + 5), 1);
        check_window("p1 w0");
        for (int w = 1; w < 3; w++) begin
            wait_win("p1", WIN_CYC + 100, cyc);
            check_val("p1 period", cyc, WIN_CYC + 1);
            check_window($sformatf("p1 w%0d", w));
        end

        // Reset in the middle of a window; channel 1 drops to 25 MHz meanwhile.
        cycles(400);
        rst_n = 1'b0;
        #0.3;
        check_reset_vals("mid rst");
        mon_per[1] = 40.0;
        cycles(10);
        rst_n          = 1'b1;
        model_err      = 0;
        model_lock_err = 1'b0;
        model_rise     = 1;
        wait_win("p2 first", 1400, cyc);
        check_val($sformatf("p2 restart latency=%0d", cyc),
                  (cyc >= SETTLE_CYC + WIN_CYC + 4) && (cyc <= SETTLE_CYC + WIN_CYC + 8), 1);
        check_window("p2 w0");
        for (int w = 1; w < 9; w++) begin
            wait_win("p2", WIN_CYC + 100, cyc);
            check_val("p2 period", cyc, WIN_CYC + 1);
            check_window($sformatf("p2 w%0d", w));
        end

        // Random frequencies and expectations, lock held high across the reset.
        rst_n = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) begin
            mon_per[i]  = per_opts[$urandom_range(0, 6)];
            mon_duty[i] = 0.5;
        end
`ifdef PLL_MON_DUTY_EN
        mon_per[0]  = 20.0;
        mon_duty[0] = 0.3;
`endif
        for (int i = 0; i < NUM_CLK; i++) exp_v[i] = CNT_W'(pick_exp(ideal_cnt(i)));
        win_exp = exp_v;
        cycles(40);
        rst_n          = 1'b1;
        model_err      = 0;
        model_lock_err = 1'b0;
        model_rise     = 1;
        wait_win("p3 first", 1400, cyc);
        check_window("p3 w0");
        for (int i = 0; i < NUM_CLK; i++) exp_v[i] = CNT_W'(pick_exp(ideal_cnt(i)));
        for (int w = 1; w < 8; w++) begin
            wait_win("p3", WIN_CYC + 100, cyc);
            check_val("p3 period", cyc, WIN_CYC + 1);
            check_window($sformatf("p3 w%0d", w));
            for (int i = 0; i < NUM_CLK; i++) exp_v[i] = CNT_W'(pick_exp(ideal_cnt(i)));
        end

        // Lock loss mid-window, relocks and lock_rise_cnt saturation.
        bus.pll_lock = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) begin
            mon_per[i]  = 20.0;
            mon_duty[i] = 0.5;
            exp_v[i]    = CNT_W'(100);
        end
        win_exp = exp_v;
        cycles(40);
        pulse_reset();
        cycles(5);
        bus.pll_lock = 1'b1;
        model_rise   = 1;
        wait_win("p4 first", 1400, cyc);
        check_window("p4 w0");
        cycles(300);
        bus.pll_lock = 1'b0;
        cycles(10);
        add_err();
        model_lock_err = 1'b1;
        check_status("p4 fall1");
        seen = 1'b0;
        for (int c = 0; c < WIN_CYC + 50; c++) begin
            @(negedge clk_tb);
            if (bus.win_done) seen = 1'b1;
        end
        check_val("p4 no win_done after fall", seen, 0);
        for (int k = 0; k < 3; k++) begin
            bus.pll_lock = 1'b1;
            cycles(10);
            if (model_rise < 3) model_rise++;
            add_err();
            check_status($sformatf("p4 relock%0d", k));
            if (k < 2) begin
                cycles(400);
                bus.pll_lock = 1'b0;
                cycles(10);
                add_err();
                check_status($sformatf("p4 fall%0d", k + 2));
                cycles(10);
            end
        end
        wait_win("p4 resume", 1400, cyc);
        check_window("p4 resume");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
